// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Program-counter and instruction-fetch front end. It issues one request at
//   a time to instruction memory, captures the returned word and presents it
//   to decode with its address. Taken-branch redirects may arrive at any time.
//   A redirect that lands while a request is outstanding leaves that request
//   in flight and marks its response as stale, so the memory handshake is
//   never broken.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   next_pc       : redirect target; bits [1:0] are ignored
//   redirect      : load next_pc as the new fetch address
//   imem_addr     : memory request address (held until ack)
//   imem_req      : memory request strobe
//   imem_ack      : memory response strobe, imem_rdata valid with it
//   imem_rdata    : returned instruction word
//   instr         : fetched instruction for decode
//   instr_pc      : address of instr
//   pc_plus4      : instr_pc + 4 (wraps modulo 2^32)
//   instr_valid   : instr / instr_pc valid
//   instr_ready   : decode accepts the instruction
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc,
    input  logic        redirect,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(32'hFFFF_FFFC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic            instr_valid_q, instr_valid_d;
    logic            imem_req_q, imem_req_d;

    logic [XLEN-1:0] target;
    logic            handshake;

    // Redirect targets are always word aligned.
    assign target    = next_pc & ALIGN_MASK;
    assign handshake = instr_valid_q && instr_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            pc_plus4_q    <= WORD_BYTES;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            pc_plus4_q    <= pc_plus4_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
        end
    end

    // Next-state and register updates.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                if (redirect) begin
                    pc_d       = target;
                    req_addr_d = target;
                end else begin
                    req_addr_d = pc_q;
                end
            end

            ST_FETCH: begin
                if (redirect && imem_ack) begin
                    // Response belongs to the old path: drop it, reissue.
                    pc_d       = target;
                    req_addr_d = target;
                end else if (redirect) begin
                    // Request must complete before the new one can go out.
                    pc_d    = target;
                    state_d = ST_DRAIN;
                end else if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = req_addr_q;
                    instr_valid_d = 1'b1;
                    pc_d          = req_addr_q + WORD_BYTES;
                    state_d       = ST_HOLD;
                end
            end

            ST_DRAIN: begin
                // Stale request in flight; latest redirect wins.
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_ack) begin
                    req_addr_d = redirect ? target : pc_q;
                    state_d    = ST_FETCH;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    instr_valid_d = 1'b0;
                    pc_d          = target;
                    req_addr_d    = target;
                    state_d       = ST_FETCH;
                end else if (handshake) begin
                    instr_valid_d = 1'b0;
                    req_addr_d    = pc_q;
                    state_d       = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered copies of the derived outputs track the next state.
        imem_req_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
        pc_plus4_d = instr_pc_d + WORD_BYTES;
    end

    assign imem_addr   = req_addr_q;
    assign imem_req    = imem_req_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc_plus4    = pc_plus4_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//   Directed bench for pc_fetch_unit. A transaction-level model (what address
//   is wanted next, whether a request is in flight and stale, what instruction
//   is held) is checked against the DUT every cycle, alongside literal checks
//   of the reference scenarios.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready;

    int n_cmp;
    int n_fail;

    // Model of the fetch unit in transaction terms.
    logic        m_started;
    logic [31:0] m_want;
    logic        m_busy;
    logic [31:0] m_ra;
    logic        m_stale;
    logic        m_have;
    logic [31:0] m_hi;
    logic [31:0] m_hpc;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .next_pc     (next_pc),
        .redirect    (redirect),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_want    = 32'h0000_0000;
        m_busy    = 1'b0;
        m_ra      = 32'h0000_0000;
        m_stale   = 1'b0;
        m_have    = 1'b0;
        m_hi      = 32'h0;
        m_hpc     = 32'h0;
    endtask

    // Advance the model by one clock using the inputs presented at the edge.
    task automatic model_step();
        logic [31:0] n;
        n = next_pc & 32'hFFFF_FFFC;
        if (!m_started) begin
            m_started = 1'b1;
            if (redirect) m_want = n;
            m_busy  = 1'b1;
            m_ra    = m_want;
            m_stale = 1'b0;
        end else if (m_busy && !m_stale) begin
            if (imem_ack && redirect) begin
                m_want = n;
                m_ra   = n;
            end else if (redirect) begin
                m_want  = n;
                m_stale = 1'b1;
            end else if (imem_ack) begin
                m_have = 1'b1;
                m_hi   = imem_rdata;
                m_hpc  = m_ra;
                m_want = m_ra + 32'd4;
                m_busy = 1'b0;
            end
        end else if (m_busy) begin
            if (redirect) m_want = n;
            if (imem_ack) begin
                m_ra    = m_want;
                m_stale = 1'b0;
            end
        end else if (m_have) begin
            if (redirect) begin
                m_have = 1'b0;
                m_want = n;
                m_busy = 1'b1;
                m_ra   = n;
            end else if (instr_ready) begin
                m_have = 1'b0;
                m_busy = 1'b1;
                m_ra   = m_want;
            end
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n && m_started) begin
            chk("mdl_imem_req", {31'b0, imem_req}, {31'b0, m_busy});
            if (m_busy) chk("mdl_imem_addr", imem_addr, m_ra);
            chk("mdl_instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
            if (m_have) begin
                chk("mdl_instr", instr, m_hi);
                chk("mdl_instr_pc", instr_pc, m_hpc);
                chk("mdl_pc_plus4", pc_plus4, m_hpc + 32'd4);
            end
        end
    end

    // One clock: drive inputs, take the edge, step the model, settle at negedge.
    task automatic cyc(input logic ack, input logic [31:0] rd, input logic r,
                       input logic [31:0] n, input logic y);
        imem_ack    = ack;
        imem_rdata  = rd;
        redirect    = r;
        next_pc     = n;
        instr_ready = y;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   {31'b0, imem_req},    32'd0);
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, instr,                32'd0);
        chk({tag, "_ipc"},   instr_pc,             32'd0);
        chk({tag, "_pcp4"},  pc_plus4,             32'd4);
        chk({tag, "_addr"},  imem_addr,            32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        model_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0; redirect = 1'b0;
        next_pc = 32'h0; instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        chk("rel_req_low", {31'b0, imem_req}, 32'd0);

        // Zero-wait memory, decode always ready.
        cyc(1'b1, 32'h2002_0005, 1'b0, 32'h0, 1'b1);
        chk("seq_req0", {31'b0, imem_req}, 32'd1);
        chk("seq_addr0", imem_addr, 32'h0);
        cyc(1'b1, 32'h2002_0005, 1'b0, 32'h0, 1'b1);
        chk("seq_valid0", {31'b0, instr_valid}, 32'd1);
        chk("seq_ipc0", instr_pc, 32'h0);
        chk("seq_pcp4_0", pc_plus4, 32'h4);
        chk("seq_instr0", instr, 32'h2002_0005);
        chk("seq_req_hold", {31'b0, imem_req}, 32'd0);
        cyc(1'b1, 32'h2002_0005, 1'b0, 32'h0, 1'b1);
        chk("seq_addr4", imem_addr, 32'h4);
        cyc(1'b1, 32'h2002_0005, 1'b0, 32'h0, 1'b1);
        chk("seq_ipc4", instr_pc, 32'h4);
        cyc(1'b1, 32'h2002_0005, 1'b0, 32'h0, 1'b1);
        chk("seq_addr8", imem_addr, 32'h8);

        // Slow ack at addr 8 with redirect in first wait cycle.
        cyc(1'b0, 32'h0, 1'b1, 32'h0000_0043, 1'b1);
        chk("drn_addr_w1", imem_addr, 32'h8);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("drn_addr_w2", imem_addr, 32'h8);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("drn_req_w3", {31'b0, imem_req}, 32'd1);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        chk("drn_dropped", {31'b0, instr_valid}, 32'd0);
        chk("drn_new_addr", imem_addr, 32'h40);
        cyc(1'b1, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
        chk("drn_ipc", instr_pc, 32'h40);
        chk("drn_instr", instr, 32'h1111_1111);

        // Decode stalls for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_ipc", instr_pc, 32'h40);
            chk("stall_instr", instr, 32'h1111_1111);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
        end

        // Redirect together with handshake.
        cyc(1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b1);
        chk("hsr_valid", {31'b0, instr_valid}, 32'd0);
        chk("hsr_addr", imem_addr, 32'h100);
        cyc(1'b1, 32'h2222_2222, 1'b0, 32'h0, 1'b0);
        chk("hsr_ipc", instr_pc, 32'h100);

        // Address wrap at the top of memory.
        cyc(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(1'b1, 32'h3333_3333, 1'b0, 32'h0, 1'b0);
        chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_pcp4", pc_plus4, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("wrap_next", imem_addr, 32'h0);

        // Redirect coincident with ack in FETCH.
        cyc(1'b1, 32'h5555_5555, 1'b1, 32'h0000_0205, 1'b1);
        chk("fra_valid", {31'b0, instr_valid}, 32'd0);
        chk("fra_addr", imem_addr, 32'h204);

        // Redirect, then ack plus redirect in DRAIN.
        cyc(1'b0, 32'h0, 1'b1, 32'h0000_0300, 1'b1);
        cyc(1'b1, 32'h6666_6666, 1'b1, 32'h0000_0403, 1'b1);
        chk("dra_valid", {31'b0, instr_valid}, 32'd0);
        chk("dra_addr", imem_addr, 32'h400);

        // Reset pulse while draining.
        cyc(1'b0, 32'h0, 1'b1, 32'h0000_0500, 1'b1);
        chk("pre_rst_req", {31'b0, imem_req}, 32'd1);
        rst_n = 1'b0;
        model_reset();
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_0BAD;
        redirect = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("inrst");
        rst_n = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("rst2_addr", imem_addr, 32'h0);
        chk("rst2_req", {31'b0, imem_req}, 32'd1);
        chk("rst2_novalid", {31'b0, instr_valid}, 32'd0);
        cyc(1'b1, 32'h4444_4444, 1'b0, 32'h0, 1'b1);
        chk("rst2_ipc", instr_pc, 32'h0);
        chk("rst2_instr", instr, 32'h4444_4444);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
